// File: rtl/x_dl_sampler.sv
// Delay-line measurement engine: decodes thermometer samples from one selected
// line to an edge position and reduces 2^n of them to avg/min/max/span.
module x_dl_sampler #(
    parameter int P_WIDTH     = 32,
    parameter int P_CHANNELS  = 4,
    parameter int P_MAX_LOG2N = 8
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [P_CHANNELS*P_WIDTH-1:0] i_dl,
    input  logic [P_CHANNELS-1:0]         i_dl_valid,
    input  logic                          i_cmd_valid,
    output logic                          o_cmd_accept,
    input  logic [3:0]                    i_cmd_chan,
    input  logic [1:0]                    i_cmd_mode,
    input  logic [3:0]                    i_cmd_log2n,
    input  logic                          i_abort,
    output logic                          o_res_valid,
    input  logic                          i_res_accept,
    output logic [15:0]                   o_res_data,
    output logic                          o_res_err,
    output logic                          o_busy
);

    // state     | meaning
    // S_IDLE    | waiting for a command
    // S_CAPTURE | accumulating samples from the selected line
    // S_RESULT  | result held until the consumer accepts it

    localparam int POS_W = $clog2(P_WIDTH + 1);
    localparam int ACC_W = POS_W + P_MAX_LOG2N;
    localparam int CNT_W = P_MAX_LOG2N + 1;

    typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_RESULT} state_t;

    state_t             state_q;
    logic [3:0]         chan_q;
    logic [1:0]         mode_q;
    logic [3:0]         log2n_q;
    logic [ACC_W-1:0]   sum_q;
    logic [POS_W-1:0]   min_q;
    logic [POS_W-1:0]   max_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               res_valid_q;
    logic               res_err_q;
    logic [15:0]        res_data_q;

    logic [P_WIDTH-1:0] sel_sample;
    logic               sel_strobe;
    logic [POS_W-1:0]   pos;
    logic               run;
    logic [ACC_W-1:0]   sum_d;
    logic [POS_W-1:0]   min_d;
    logic [POS_W-1:0]   max_d;
    logic [ACC_W-1:0]   avg_d;
    logic [15:0]        res_d;
    logic [CNT_W-1:0]   n_last;
    logic [3:0]         log2n_clamp;
    logic               chan_bad;

    // Mux rather than a variable part-select so an out-of-range channel never indexes i_dl.
    always_comb begin
        sel_sample = '0;
        sel_strobe = 1'b0;
        for (int c = 0; c < P_CHANNELS; c++) begin
            if (chan_q == 4'(c)) begin
                sel_sample = i_dl[c*P_WIDTH +: P_WIDTH];
                sel_strobe = i_dl_valid[c];
            end
        end
    end

    // Count the run of ones from bit 0; anything past the first zero is a bubble.
    always_comb begin
        pos = '0;
        run = 1'b1;
        for (int b = 0; b < P_WIDTH; b++) begin
            if (run && sel_sample[b]) pos = POS_W'(b + 1);
            else                      run = 1'b0;
        end
    end

    always_comb begin
        sum_d  = sum_q + ACC_W'(pos);
        min_d  = (pos < min_q) ? pos : min_q;
        max_d  = (pos > max_q) ? pos : max_q;
        avg_d  = sum_d >> log2n_q;
        n_last = (CNT_W'(1) << log2n_q) - CNT_W'(1);
        res_d  = '0;
        case (mode_q)
            2'd0:    res_d = 16'(avg_d);
            2'd1:    res_d = 16'(min_d);
            2'd2:    res_d = 16'(max_d);
            default: res_d = 16'(max_d - min_d);
        endcase
    end

    assign log2n_clamp = (int'(i_cmd_log2n) > P_MAX_LOG2N) ? 4'(P_MAX_LOG2N) : i_cmd_log2n;
    assign chan_bad    = ({1'b0, i_cmd_chan} >= 5'(P_CHANNELS));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= S_IDLE;
            chan_q      <= '0;
            mode_q      <= '0;
            log2n_q     <= '0;
            sum_q       <= '0;
            min_q       <= '0;
            max_q       <= '0;
            cnt_q       <= '0;
            res_valid_q <= 1'b0;
            res_err_q   <= 1'b0;
            res_data_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (i_cmd_valid) begin
                        chan_q  <= i_cmd_chan;
                        mode_q  <= i_cmd_mode;
                        log2n_q <= log2n_clamp;
                        sum_q   <= '0;
                        min_q   <= POS_W'(P_WIDTH);
                        max_q   <= '0;
                        cnt_q   <= '0;
                        if (chan_bad) begin
                            state_q     <= S_RESULT;
                            res_valid_q <= 1'b1;
                            res_err_q   <= 1'b1;
                            res_data_q  <= '0;
                        end else begin
                            state_q <= S_CAPTURE;
                        end
                    end
                end
                S_CAPTURE: begin
                    if (i_abort) begin
                        state_q <= S_IDLE;
                    end else if (sel_strobe) begin
                        sum_q <= sum_d;
                        min_q <= min_d;
                        max_q <= max_d;
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (cnt_q == n_last) begin
                            state_q     <= S_RESULT;
                            res_valid_q <= 1'b1;
                            res_err_q   <= 1'b0;
                            res_data_q  <= res_d;
                        end
                    end
                end
                S_RESULT: begin
                    if (i_res_accept) begin
                        state_q     <= S_IDLE;
                        res_valid_q <= 1'b0;
                        res_err_q   <= 1'b0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign o_cmd_accept = (state_q == S_IDLE);
    assign o_busy       = (state_q != S_IDLE);
    assign o_res_valid  = res_valid_q;
    assign o_res_data   = res_data_q;
    assign o_res_err    = res_err_q;

endmodule

// File: tb/tb_x_dl_sampler.sv
// Randomised bench for x_dl_sampler against a sample-list reference model.
module tb_x_dl_sampler;

    localparam int W  = 32;
    localparam int CH = 4;

    logic              i_clk = 1'b0;
    logic              i_rst;
    logic [CH*W-1:0]   i_dl;
    logic [CH-1:0]     i_dl_valid;
    logic              i_cmd_valid;
    logic              o_cmd_accept;
    logic [3:0]        i_cmd_chan;
    logic [1:0]        i_cmd_mode;
    logic [3:0]        i_cmd_log2n;
    logic              i_abort;
    logic              o_res_valid;
    logic              i_res_accept;
    logic [15:0]       o_res_data;
    logic              o_res_err;
    logic              o_busy;

    int n_checks = 0;
    int n_errors = 0;
    logic [W-1:0] samp [256];

    x_dl_sampler #(.P_WIDTH(W), .P_CHANNELS(CH), .P_MAX_LOG2N(8)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_dl(i_dl), .i_dl_valid(i_dl_valid),
        .i_cmd_valid(i_cmd_valid), .o_cmd_accept(o_cmd_accept),
        .i_cmd_chan(i_cmd_chan), .i_cmd_mode(i_cmd_mode), .i_cmd_log2n(i_cmd_log2n),
        .i_abort(i_abort), .o_res_valid(o_res_valid), .i_res_accept(i_res_accept),
        .o_res_data(o_res_data), .o_res_err(o_res_err), .o_busy(o_busy)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    function automatic int ref_pos(input logic [W-1:0] v);
        int p = 0;
        while (p < W && v[p]) p++;
        return p;
    endfunction

    function automatic logic [W-1:0] rnd_therm();
        int p = $urandom_range(0, W);
        logic [63:0] ones, junk;
        logic [W-1:0] r;
        ones = (64'd1 << p) - 64'd1;
        junk = {$urandom, $urandom};
        if (p < W) junk = junk & ~((64'd1 << (p + 1)) - 64'd1);
        else       junk = '0;
        ones = ones | junk;
        r = ones[W-1:0];
        return r;
    endfunction

    function automatic logic [CH*W-1:0] rnd_dl();
        logic [CH*W-1:0] v;
        for (int c = 0; c < CH; c++) v[c*W +: W] = $urandom;
        return v;
    endfunction

    // Full command/sample/result transaction; samples come from samp[].
    task automatic run_meas(input int chan, input int mode, input int log2n, input bit noise);
        int eff, n, sum, mn, mx, exp_data, hold;
        bit bad;
        eff = (log2n > 8) ? 8 : log2n;
        n   = 1 << eff;
        bad = (chan >= CH);
        sum = 0; mn = W; mx = 0;
        for (int k = 0; k < n; k++) begin
            int p = ref_pos(samp[k]);
            sum += p;
            if (p < mn) mn = p;
            if (p > mx) mx = p;
        end
        case (mode)
            0: exp_data = sum / n;
            1: exp_data = mn;
            2: exp_data = mx;
            default: exp_data = mx - mn;
        endcase
        if (bad) exp_data = 0;

        i_cmd_valid = 1'b1;
        i_cmd_chan  = 4'(chan);
        i_cmd_mode  = 2'(mode);
        i_cmd_log2n = 4'(log2n);
        if (noise) begin
            i_dl       = rnd_dl();
            i_dl_valid = 4'($urandom);
        end
        chk("cmd_accept", o_cmd_accept, 1);
        tick();
        i_cmd_valid = 1'b0;
        i_dl_valid  = '0;

        if (!bad) begin
            chk("busy_cap", o_busy, 1);
            for (int k = 0; k < n; k++) begin
                if (noise) begin
                    int gaps = $urandom_range(0, 2);
                    for (int g = 0; g < gaps; g++) begin
                        i_dl       = rnd_dl();
                        i_dl_valid = 4'($urandom) & ~(4'(1) << chan);
                        tick();
                    end
                end
                i_dl = noise ? rnd_dl() : '0;
                i_dl[chan*W +: W] = samp[k];
                i_dl_valid = (noise ? 4'($urandom) : 4'(0)) | (4'(1) << chan);
                if (k == n - 1) chk("pre_last_valid", o_res_valid, 0);
                tick();
                i_dl_valid = '0;
            end
        end

        chk("res_valid", o_res_valid, 1);
        chk("res_data", o_res_data, exp_data);
        chk("res_err", o_res_err, bad ? 1 : 0);
        hold = bad ? 5 : $urandom_range(1, 3);
        for (int h = 0; h < hold; h++) begin
            i_abort    = 1'($urandom);
            i_dl_valid = 4'($urandom);
            i_dl       = rnd_dl();
            tick();
            chk("hold_valid", o_res_valid, 1);
            chk("hold_data", o_res_data, exp_data);
            chk("hold_err", o_res_err, bad ? 1 : 0);
        end
        i_abort      = 1'b0;
        i_dl_valid   = '0;
        i_res_accept = 1'b1;
        i_cmd_valid  = 1'b1;   // must not be taken alongside the accept
        i_cmd_chan   = 4'd0;
        tick();
        i_res_accept = 1'b0;
        i_cmd_valid  = 1'b0;
        chk("acc_valid", o_res_valid, 0);
        chk("acc_err", o_res_err, 0);
        chk("acc_busy", o_busy, 0);
        chk("acc_cmd_accept", o_cmd_accept, 1);
    endtask

    initial begin
        i_rst = 1'b1; i_dl = '0; i_dl_valid = '0; i_cmd_valid = 1'b0;
        i_cmd_chan = '0; i_cmd_mode = '0; i_cmd_log2n = '0;
        i_abort = 1'b0; i_res_accept = 1'b0;
        repeat (3) tick();
        i_rst = 1'b0;
        chk("rst_valid", o_res_valid, 0);
        chk("rst_data", o_res_data, 0);
        chk("rst_err", o_res_err, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_cmd_accept", o_cmd_accept, 1);

        // Directed edge values 3,5,7,9 in all four modes
        samp[0] = 32'h7; samp[1] = 32'h1F; samp[2] = 32'h7F; samp[3] = 32'h1FF;
        for (int m = 0; m < 4; m++) run_meas(1, m, 2, 1'b0);

        samp[0] = 32'hF7;
        run_meas(0, 0, 0, 1'b0);
        run_meas(0, 3, 0, 1'b0);

        samp[0] = '1; samp[1] = '1;
        run_meas(2, 0, 1, 1'b1);

        run_meas(7, 0, 3, 1'b0);

        // Clamped count: 256 samples
        for (int k = 0; k < 256; k++) samp[k] = rnd_therm();
        run_meas(3, 0, 15, 1'b0);

        // Abort after 100 strobes, strobe coincident with abort is dropped
        i_cmd_valid = 1'b1; i_cmd_chan = 4'd1; i_cmd_mode = 2'd0; i_cmd_log2n = 4'd15;
        tick();
        i_cmd_valid = 1'b0;
        for (int k = 0; k < 100; k++) begin
            i_dl[W +: W] = 32'hFF;
            i_dl_valid = 4'b0010;
            tick();
        end
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0; i_dl_valid = '0;
        chk("abort_busy", o_busy, 0);
        chk("abort_valid", o_res_valid, 0);
        repeat (3) tick();
        chk("abort_no_result", o_res_valid, 0);
        samp[0] = '0;
        run_meas(1, 0, 0, 1'b0);

        // Abort on what would have been the only sample
        i_cmd_valid = 1'b1; i_cmd_chan = 4'd0; i_cmd_log2n = 4'd0;
        tick();
        i_cmd_valid = 1'b0;
        i_dl[0 +: W] = 32'h3; i_dl_valid = 4'b0001; i_abort = 1'b1;
        tick();
        i_abort = 1'b0; i_dl_valid = '0;
        chk("abort_last_valid", o_res_valid, 0);
        chk("abort_last_busy", o_busy, 0);

        // Reset while a result is pending
        i_cmd_valid = 1'b1; i_cmd_chan = 4'd9;
        tick();
        i_cmd_valid = 1'b0;
        chk("pre_rst_valid", o_res_valid, 1);
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        chk("rst_res_valid", o_res_valid, 0);
        chk("rst_res_busy", o_busy, 0);
        chk("rst_res_accept", o_cmd_accept, 1);
        chk("rst_res_err", o_res_err, 0);

        // Reset mid-capture, then check accumulators start fresh
        i_cmd_valid = 1'b1; i_cmd_chan = 4'd0; i_cmd_log2n = 4'd3;
        tick();
        i_cmd_valid = 1'b0;
        i_dl[0 +: W] = '1; i_dl_valid = 4'b0001;
        repeat (2) tick();
        i_dl_valid = '0;
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        chk("rst_cap_busy", o_busy, 0);
        tick();
        chk("rst_cap_valid", o_res_valid, 0);
        samp[0] = 32'h1; samp[1] = 32'h3;
        run_meas(0, 0, 1, 1'b0);

        for (int it = 0; it < 40; it++) begin
            int chan, log2n;
            chan  = ($urandom_range(0, 9) == 0) ? $urandom_range(4, 15) : $urandom_range(0, CH - 1);
            log2n = ($urandom_range(0, 9) == 0) ? $urandom_range(9, 15) : $urandom_range(0, 5);
            for (int k = 0; k < 256; k++) samp[k] = rnd_therm();
            run_meas(chan, $urandom_range(0, 3), log2n, 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
